compute_cluster: RTL and testbench



---
 rtl/compute_cluster.sv | 239 +++++++++++++++++++++++
 tb/tb_compute_cluster.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_cluster.sv
// compute_cluster
//   Sparse-CNN compute cluster. It holds a double-buffered compressed IFM
//   (sparse map plus packed nonzero bytes) and double-buffered compressed
//   filters for COMPUTE_UNIT_NUM units. Each unit walks the AND of the IFM and
//   filter maps one chunk at a time and retires one matching position per
//   cycle. It accumulates the unsigned 8x8 products into its own output buffer
//   entry.
//
// Ports
//   clk_i, rst_i                : clock, asynchronous active-low reset
//   ifm_*_i                     : IFM slice write (map, packed bytes, valid,
//                                 slice index, write bank) and read bank
//   filter_*_i                  : same as the IFM ports, for filters;
//                                 filter_wr_order_sel_i picks the target unit
//   init_i                      : load phase; its falling edge starts a pass
//   chunk_start_i               : start-pass pulse (honoured when not running)
//   rd_sparsemap_num_i          : chunks per pass minus one
//   acc_buf_sel_i               : output entry accumulated by the next pass
//   total_chunk_end_o           : registered one-cycle pass-done pulse
//   out_buf_sel_i,
//   com_unit_out_buf_sel_i      : read-port entry / unit select
//   out_buf_dat_o               : read data
//
// Build option
//   OUT_BUF_REG_EN : when defined, out_buf_dat_o is registered (1-cycle read
//                    latency); otherwise the read port is combinational.
module compute_cluster #(
  parameter int unsigned MEM_SIZE         = 256,
  parameter int unsigned BUS_SIZE         = 32,
  parameter int unsigned PREFIX_SUM_SIZE  = 32,
  parameter int unsigned COMPUTE_UNIT_NUM = 4,
  parameter int unsigned OUTPUT_BUF_NUM   = 8,
  parameter int unsigned OUTPUT_BUF_SIZE  = 32
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [BUS_SIZE-1:0]                         ifm_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]                       ifm_nonzero_data_i,
  input  logic                                        ifm_wr_valid_i,
  input  logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0]        ifm_wr_count_i,
  input  logic                                        ifm_wr_sel_i,
  input  logic                                        ifm_rd_sel_i,
  input  logic [BUS_SIZE-1:0]                         filter_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]                       filter_nonzero_data_i,
  input  logic                                        filter_wr_valid_i,
  input  logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0]        filter_wr_count_i,
  input  logic                                        filter_wr_sel_i,
  input  logic                                        filter_rd_sel_i,
  input  logic [$clog2(OUTPUT_BUF_NUM)-1:0]           filter_wr_order_sel_i,
  input  logic                                        init_i,
  input  logic                                        chunk_start_i,
  input  logic [$clog2(MEM_SIZE/PREFIX_SUM_SIZE)-1:0] rd_sparsemap_num_i,
  output logic                                        total_chunk_end_o,
  input  logic [$clog2(OUTPUT_BUF_NUM)-1:0]           acc_buf_sel_i,
  input  logic [$clog2(OUTPUT_BUF_NUM)-1:0]           out_buf_sel_i,
  input  logic [$clog2(COMPUTE_UNIT_NUM)-1:0]         com_unit_out_buf_sel_i,
  output logic [OUTPUT_BUF_SIZE-1:0]                  out_buf_dat_o
);

  localparam int unsigned CH_W  = $clog2(MEM_SIZE/PREFIX_SUM_SIZE);
  localparam int unsigned OB_W  = $clog2(OUTPUT_BUF_NUM);
  localparam int unsigned CU_W  = $clog2(COMPUTE_UNIT_NUM);
  localparam int unsigned IDX_W = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  // Storage: maps as bit vectors, nonzero bytes packed at the same offsets.
  logic [MEM_SIZE-1:0]   ifm_map_q  [2];
  logic [MEM_SIZE*8-1:0] ifm_data_q [2];
  logic [MEM_SIZE-1:0]   filt_map_q  [2][COMPUTE_UNIT_NUM];
  logic [MEM_SIZE*8-1:0] filt_data_q [2][COMPUTE_UNIT_NUM];

  logic [OUTPUT_BUF_NUM-1:0][OUTPUT_BUF_SIZE-1:0] out_buf_q [COMPUTE_UNIT_NUM];

  state_e                      state_q, state_d;
  logic                        init_q;
  logic                        end_q;
  logic                        start;
  logic [OB_W-1:0]             acc_sel_q;
  logic                        ifm_rd_q, filt_rd_q;
  logic [CH_W-1:0]             num_q;
  logic [COMPUTE_UNIT_NUM-1:0] unit_done_q, unit_done_d;

  logic [IDX_W-1:0] ifm_wr_off, filt_wr_off;
  logic [CU_W-1:0]  fw_unit;

  function automatic logic [IDX_W-1:0] popcnt(input logic [PREFIX_SUM_SIZE-1:0] v);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < PREFIX_SUM_SIZE; i++) c = c + IDX_W'(v[i]);
    return c;
  endfunction

  // ---------------- write path ----------------
  assign ifm_wr_off  = IDX_W'(ifm_wr_count_i) * IDX_W'(BUS_SIZE);
  assign filt_wr_off = IDX_W'(filter_wr_count_i) * IDX_W'(BUS_SIZE);
  assign fw_unit     = CU_W'(32'(filter_wr_order_sel_i) % COMPUTE_UNIT_NUM);

  always_ff @(posedge clk_i) begin
    if (ifm_wr_valid_i) begin
      ifm_map_q[ifm_wr_sel_i][ifm_wr_off +: BUS_SIZE]             <= ifm_sparsemap_i;
      ifm_data_q[ifm_wr_sel_i][{ifm_wr_off, 3'b000} +: BUS_SIZE*8] <= ifm_nonzero_data_i;
    end
    if (filter_wr_valid_i) begin
      filt_map_q[filter_wr_sel_i][fw_unit][filt_wr_off +: BUS_SIZE]              <= filter_sparsemap_i;
      filt_data_q[filter_wr_sel_i][fw_unit][{filt_wr_off, 3'b000} +: BUS_SIZE*8] <= filter_nonzero_data_i;
    end
  end

  // ---------------- pass control ----------------
  assign start = (state_q != S_RUN) && (chunk_start_i || (init_q && !init_i));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (&unit_done_d) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      init_q      <= 1'b0;
      end_q       <= 1'b0;
      acc_sel_q   <= '0;
      ifm_rd_q    <= 1'b0;
      filt_rd_q   <= 1'b0;
      num_q       <= '0;
      unit_done_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_i;
      end_q   <= (state_d == S_DONE);
      if (start) begin
        acc_sel_q   <= acc_buf_sel_i;
        ifm_rd_q    <= ifm_rd_sel_i;
        filt_rd_q   <= filter_rd_sel_i;
        num_q       <= rd_sparsemap_num_i;
        unit_done_q <= '0;
      end else begin
        unit_done_q <= unit_done_d;
      end
    end
  end

  assign total_chunk_end_o = end_q;

  // ---------------- compute units ----------------
  for (genvar u = 0; u < COMPUTE_UNIT_NUM; u++) begin : g_unit
    logic [CH_W-1:0]            chunk_q, chunk_d;
    logic [PREFIX_SUM_SIZE-1:0] used_q, used_d;
    logic [IDX_W-1:0]           ibase_q, ibase_d, fbase_q, fbase_d;
    logic [IDX_W-1:0]           off, iidx, fidx;
    logic [PREFIX_SUM_SIZE-1:0] imap, fmap, eff, low, below;
    logic [7:0]                 ia, fa;
    logic [15:0]                prod;
    logic                       acc_en, done_d;

    // Positions already retired in this chunk are masked via used_q; the
    // lowest remaining bit is retired each cycle. The data index is the running
    // popcount of earlier chunks plus the prefix count below that bit.
    always_comb begin
      off    = IDX_W'(chunk_q) * IDX_W'(PREFIX_SUM_SIZE);
      imap   = ifm_map_q[ifm_rd_q][off +: PREFIX_SUM_SIZE];
      fmap   = filt_map_q[filt_rd_q][u][off +: PREFIX_SUM_SIZE];
      eff    = imap & fmap & ~used_q;
      low    = eff & (~eff + PREFIX_SUM_SIZE'(1));
      below  = low - PREFIX_SUM_SIZE'(1);
      iidx   = ibase_q + popcnt(imap & below);
      fidx   = fbase_q + popcnt(fmap & below);
      ia     = ifm_data_q[ifm_rd_q][{iidx, 3'b000} +: 8];
      fa     = filt_data_q[filt_rd_q][u][{fidx, 3'b000} +: 8];
      prod   = 16'(ia) * 16'(fa);
      acc_en  = 1'b0;
      chunk_d = chunk_q;
      used_d  = used_q;
      ibase_d = ibase_q;
      fbase_d = fbase_q;
      done_d  = unit_done_q[u];
      if (state_q == S_RUN && !unit_done_q[u]) begin
        acc_en = |eff;
        if ((eff & ~low) == '0) begin
          // Last (or no) match in this chunk: move on in the same cycle.
          chunk_d = chunk_q + CH_W'(1);
          used_d  = '0;
          ibase_d = ibase_q + popcnt(imap);
          fbase_d = fbase_q + popcnt(fmap);
          if (chunk_q == num_q) done_d = 1'b1;
        end else begin
          used_d = used_q | low;
        end
      end
    end

    assign unit_done_d[u] = done_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        chunk_q      <= '0;
        used_q       <= '0;
        ibase_q      <= '0;
        fbase_q      <= '0;
        out_buf_q[u] <= '0;
      end else if (start) begin
        chunk_q                     <= '0;
        used_q                      <= '0;
        ibase_q                     <= '0;
        fbase_q                     <= '0;
        out_buf_q[u][acc_buf_sel_i] <= '0;
      end else begin
        chunk_q <= chunk_d;
        used_q  <= used_d;
        ibase_q <= ibase_d;
        fbase_q <= fbase_d;
        if (acc_en)
          out_buf_q[u][acc_sel_q] <= out_buf_q[u][acc_sel_q] + OUTPUT_BUF_SIZE'(prod);
      end
    end
  end

  // ---------------- read port ----------------
  logic [OUTPUT_BUF_SIZE-1:0] rd_data;
  assign rd_data = out_buf_q[com_unit_out_buf_sel_i][out_buf_sel_i];

`ifdef OUT_BUF_REG_EN
  logic [OUTPUT_BUF_SIZE-1:0] rd_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rd_q <= '0;
    else        rd_q <= rd_data;
  end
  assign out_buf_dat_o = rd_q;
`else
  assign out_buf_dat_o = rd_data;
`endif

endmodule

// File: tb/tb_compute_cluster.sv
module tb_compute_cluster;
  localparam int NU = 4;
  localparam int MS = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [31:0]  i_map, f_map;
  logic [255:0] i_dat, f_dat;
  logic         i_v, f_v, i_ws, i_rs, f_ws, f_rs;
  logic [2:0]   i_cnt, f_cnt, f_ord;
  logic         init, cstart;
  logic [2:0]   rnum;
  logic         end_o;
  logic [2:0]   acc_sel, ob_sel;
  logic [1:0]   cu_sel;
  logic [31:0]  dat_o;

  compute_cluster dut (
    .clk_i                  (clk),
    .rst_i                  (rst_n),
    .ifm_sparsemap_i        (i_map),
    .ifm_nonzero_data_i     (i_dat),
    .ifm_wr_valid_i         (i_v),
    .ifm_wr_count_i         (i_cnt),
    .ifm_wr_sel_i           (i_ws),
    .ifm_rd_sel_i           (i_rs),
    .filter_sparsemap_i     (f_map),
    .filter_nonzero_data_i  (f_dat),
    .filter_wr_valid_i      (f_v),
    .filter_wr_count_i      (f_cnt),
    .filter_wr_sel_i        (f_ws),
    .filter_rd_sel_i        (f_rs),
    .filter_wr_order_sel_i  (f_ord),
    .init_i                 (init),
    .chunk_start_i          (cstart),
    .rd_sparsemap_num_i     (rnum),
    .total_chunk_end_o      (end_o),
    .acc_buf_sel_i          (acc_sel),
    .out_buf_sel_i          (ob_sel),
    .com_unit_out_buf_sel_i (cu_sel),
    .out_buf_dat_o          (dat_o)
  );

  // Bench-side copy of what is loaded into each bank.
  logic [255:0] t_imap [2];
  logic [7:0]   t_idata [2][MS];
  logic [255:0] t_fmap [2][NU];
  logic [7:0]   t_fdata [2][NU][MS];

  logic [31:0] lat_q [$];
  logic [31:0] res_q [$];

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Dense reference: walk every position, decompressing both operands.
  function automatic logic [31:0] ref_dot(input int ib, input int fb, input int u, input int num);
    logic [31:0] acc;
    int ic, fc;
    acc = '0; ic = 0; fc = 0;
    for (int p = 0; p < (num + 1) * 32; p++) begin
      if (t_imap[ib][p] && t_fmap[fb][u][p])
        acc = acc + 32'(t_idata[ib][ic]) * 32'(t_fdata[fb][u][fc]);
      if (t_imap[ib][p]) ic++;
      if (t_fmap[fb][u][p]) fc++;
    end
    return acc;
  endfunction

  function automatic int exp_cycles(input int ib, input int fb, input int num);
    int best, s, n;
    best = 0;
    for (int u = 0; u < NU; u++) begin
      s = 0;
      for (int c = 0; c <= num; c++) begin
        n = 0;
        for (int b = 0; b < 32; b++)
          if (t_imap[ib][c*32+b] && t_fmap[fb][u][c*32+b]) n++;
        s += (n == 0) ? 1 : n;
      end
      if (s > best) best = s;
    end
    return best;
  endfunction

  task automatic clear_bank(input int b);
    t_imap[b] = '0;
    for (int p = 0; p < MS; p++) t_idata[b][p] = 8'd0;
    for (int u = 0; u < NU; u++) begin
      t_fmap[b][u] = '0;
      for (int p = 0; p < MS; p++) t_fdata[b][u][p] = 8'd0;
    end
  endtask

  task automatic rand_bank(input int b);
    for (int c = 0; c < 8; c++) t_imap[b][c*32 +: 32] = $urandom;
    for (int p = 0; p < MS; p++) t_idata[b][p] = 8'($urandom_range(0, 255));
    for (int u = 0; u < NU; u++) begin
      for (int c = 0; c < 8; c++) t_fmap[b][u][c*32 +: 32] = $urandom;
      for (int p = 0; p < MS; p++) t_fdata[b][u][p] = 8'($urandom_range(0, 255));
    end
  endtask

  // IFM slices are written in the same cycles as unit 0's filter slices.
  // Bank 1 filters use an order select with the upper bit set.
  task automatic load_bank(input int b);
    for (int u = 0; u < NU; u++)
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        f_map = t_fmap[b][u][c*32 +: 32];
        for (int i = 0; i < 32; i++) f_dat[i*8 +: 8] = t_fdata[b][u][c*32+i];
        f_v = 1'b1; f_ws = 1'(b); f_ord = 3'(u + 4*b); f_cnt = 3'(c);
        if (u == 0) begin
          i_map = t_imap[b][c*32 +: 32];
          for (int i = 0; i < 32; i++) i_dat[i*8 +: 8] = t_idata[b][c*32+i];
          i_v = 1'b1; i_ws = 1'(b); i_cnt = 3'(c);
        end else begin
          i_v = 1'b0;
        end
      end
    @(negedge clk);
    i_v = 1'b0; f_v = 1'b0;
  endtask

  task automatic start_pass(input int acc, input int ib, input int fb, input int num, input bit via_init);
    lat_q.push_back(32'(exp_cycles(ib, fb, num)));
    for (int u = 0; u < NU; u++) res_q.push_back(ref_dot(ib, fb, u, num));
    acc_sel = 3'(acc); i_rs = 1'(ib); f_rs = 1'(fb); rnum = 3'(num);
    if (via_init) init = 1'b0;
    else          cstart = 1'b1;
    @(negedge clk);
    cstart = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k;
    k = 0;
    while (end_o !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(k), lat_q.pop_front());
  endtask

  task automatic read_results(input int entry, input string tag);
    for (int u = 0; u < NU; u++) begin
      cu_sel = 2'(u); ob_sel = 3'(entry);
      @(negedge clk);
      check(tag, dat_o, res_q.pop_front());
    end
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; init = 1'b1; cstart = 1'b0;
    i_map = '0; i_dat = '0; i_v = 1'b0; i_cnt = '0; i_ws = 1'b0; i_rs = 1'b0;
    f_map = '0; f_dat = '0; f_v = 1'b0; f_cnt = '0; f_ws = 1'b0; f_rs = 1'b0; f_ord = '0;
    rnum = '0; acc_sel = '0; ob_sel = '0; cu_sel = '0;
    repeat (3) @(negedge clk);
    check("rst_end", 32'(end_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    rst_n = 1'b1;

    // All-zero maps, 8 chunks, started by the init falling edge.
    clear_bank(0);
    load_bank(0);
    start_pass(0, 0, 0, 7, 1'b1);
    wait_end("lat_zero");
    @(negedge clk);
    check("end_one_cycle", 32'(end_o), 32'd0);
    read_results(0, "zero_maps");

    // Fully dense IFM and filter 0, all data 2.
    clear_bank(0);
    t_imap[0] = '1;
    t_fmap[0][0] = '1;
    for (int p = 0; p < MS; p++) begin t_idata[0][p] = 8'd2; t_fdata[0][0][p] = 8'd2; end
    load_bank(0);
    start_pass(2, 0, 0, 7, 1'b0);
    wait_end("lat_dense");
    read_results(2, "dense");

    // Single IFM bit vs two filter-1 bits, one chunk.
    clear_bank(0);
    t_imap[0][5] = 1'b1; t_idata[0][0] = 8'd10;
    t_fmap[0][1][5] = 1'b1; t_fmap[0][1][9] = 1'b1;
    t_fdata[0][1][0] = 8'd3; t_fdata[0][1][1] = 8'd7;
    load_bank(0);
    start_pass(1, 0, 0, 0, 1'b0);
    wait_end("lat_sparse");
    read_results(1, "sparse");

    // Back-to-back: second start issued in the DONE cycle, new entry and bank.
    rand_bank(1);
    load_bank(1);
    start_pass(0, 0, 0, 7, 1'b0);
    wait_end("lat_b2b_a");
    start_pass(1, 1, 1, 7, 1'b0);
    wait_end("lat_b2b_b");
    read_results(0, "b2b_entry0");
    read_results(1, "b2b_entry1");

    // Bank swaps: mixed read banks, then bank 1 again after bank 0 rewrite.
    rand_bank(0);
    load_bank(0);
    start_pass(3, 0, 1, 7, 1'b0);
    wait_end("lat_mix_a");
    read_results(3, "mix_i0_f1");
    start_pass(4, 1, 0, 5, 1'b0);
    wait_end("lat_mix_b");
    read_results(4, "mix_i1_f0");
    start_pass(5, 1, 1, 7, 1'b0);
    wait_end("lat_bank1");
    read_results(5, "bank1_again");

    // Reset in the middle of a pass.
    acc_sel = 3'd6; i_rs = 1'b0; f_rs = 1'b0; rnum = 3'd7; cstart = 1'b1;
    @(negedge clk);
    cstart = 1'b0;
    repeat (5) @(negedge clk);
    cu_sel = 2'd0; ob_sel = 3'd3;
    rst_n = 1'b0;
    #1;
    check("midrst_dat", dat_o, 32'd0);
    check("midrst_end", 32'(end_o), 32'd0);
    pulses = 0;
    repeat (5) begin @(negedge clk); if (end_o) pulses++; end
    rst_n = 1'b1;
    repeat (300) begin @(negedge clk); if (end_o) pulses++; end
    check("no_end_after_rst", 32'(pulses), 32'd0);
    cu_sel = 2'd1; ob_sel = 3'd5;
    @(negedge clk);
    check("buf_cleared", dat_o, 32'd0);

    rand_bank(0);
    load_bank(0);
    start_pass(7, 0, 0, 7, 1'b0);
    wait_end("lat_post_rst");
    read_results(7, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
